// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request front end for a single-port SRAM.
// One SRAM access per accepted request. Read data is captured one cycle
// after issue. Every response (read data or write ack) comes back in order
// through a small response FIFO.
// Optional feature macro: SRAM_CTRL_ZERO_INIT_EN. When it is defined, a sweep
// after reset writes zero to every SRAM word before any request is accepted.
`default_nettype none

module sram_req_ctrl #(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_WORDS  = 8,
  parameter  int unsigned RSP_DEPTH  = 4,
  localparam int unsigned ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [DATA_WIDTH-1:0] sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_we_q, inflight_we_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] data_mem_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  we_mem_q;

  logic                  accept, push, pop, init_active;
  logic [CNT_W:0]        occupancy;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] be_exp;

  // Outstanding work counts both queued responses and the read still in flight,
  // so a full FIFO can never be overrun by the response of the last accept.
  assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign req_ready_o = rst_ni && (state_q == ST_RUN) &&
                       (occupancy < (CNT_W + 1)'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign push        = inflight_q;
  assign rsp_valid_o = rst_ni && (count_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_we_o    = we_mem_q[rptr_q];
  assign rsp_rdata_o = data_mem_q[rptr_q];

`ifdef SRAM_CTRL_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

  assign init_active = rst_ni && (state_q == ST_INIT);
  assign init_addr   = init_addr_q;

  // Zero-init sweep: one word per cycle, then hand over to RUN for good.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_WIDTH'(1);
      if (init_addr_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
        state_d     = ST_RUN;
        init_addr_d = '0;
      end
    end
  end

  // Sweep state; reset restarts the sweep from word 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end
`else
  assign init_active = 1'b0;
  assign init_addr   = '0;

  // Without the sweep the controller comes out of reset ready to run.
  always_comb begin
    state_d = state_q;
  end

  // Run state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end
`endif

  // Byte strobes fan out to per-bit enables.
  always_comb begin
    be_exp = '0;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      be_exp[8*k +: 8] = {8{req_strb_i[k]}};
    end
  end

  // SRAM port: sweep writes take priority, otherwise pass the request through.
  always_comb begin
    sram_req_o   = accept || init_active;
    sram_we_o    = accept && req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = (accept && req_we_i) ? be_exp : '0;
    if (init_active) begin
      sram_we_o    = 1'b1;
      sram_addr_o  = init_addr;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
  end

  // FIFO bookkeeping; pointers wrap at RSP_DEPTH so any depth works.
  always_comb begin
    inflight_d    = accept;
    inflight_we_d = req_we_i;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    if (push) wptr_d = (wptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    if (pop)  rptr_d = (rptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops anything queued or in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // Response storage: capture SRAM read data the cycle after issue, zero for acks.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      data_mem_q[wptr_q] <= inflight_we_q ? '0 : sram_rdata_i;
      we_mem_q[wptr_q]   <= inflight_we_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed vector table, hand sequences for
// back-pressure / reset corners, and a random phase scored against a
// transaction-level model (expected-response queue plus a byte-wise memory).
// Honors SRAM_CTRL_ZERO_INIT_EN when the design is built with it.
module tb_sram_req_ctrl;
  localparam int DW = 64;
  localparam int NW = 8;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, rsp_ready;
  logic [2:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_strb;
  logic          req_ready_o, rsp_valid_o, rsp_we_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_req_o, sram_we_o;
  logic [2:0]    sram_addr_o;
  logic [DW-1:0] sram_wdata_o, sram_be_o;
  logic [DW-1:0] sram_rdata = '0;

`ifdef SRAM_CTRL_ZERO_INIT_EN
  logic [DW-1:0] sram_mem [NW] = '{default: 64'hA5A5_5A5A_C3C3_3C3C};
`else
  logic [DW-1:0] sram_mem [NW] = '{default: 64'h0};
`endif
  logic [DW-1:0] ref_mem  [NW] = '{default: 64'h0};

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;
  rsp_t exp_q[$];
  int   pop_log[$];

  typedef struct {
    logic          we;
    logic [2:0]    addr;
    logic [DW-1:0] wdata;
    logic [7:0]    strb;
    logic [DW-1:0] exp_be;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vt[8];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   init_left = 0;
  logic exp_valid;
  rsp_t ent;

  sram_req_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we_o),
    .rsp_rdata_o(rsp_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behavioural model: write with bit enables, read data the next cycle.
  always @(posedge clk) begin
    if (sram_req_o) begin
      if (sram_we_o)
        sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_be_o) | (sram_wdata_o & sram_be_o);
      else
        sram_rdata <= sram_mem[sram_addr_o];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] be_of(input logic [7:0] s);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) if (s[k]) b[8*k +: 8] = 8'hFF;
    return b;
  endfunction

  // Transaction-level monitor/scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready_o), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_sram_req", 64'(sram_req_o), 64'(0));
      exp_q.delete();
`ifdef SRAM_CTRL_ZERO_INIT_EN
      init_left = NW;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
`endif
    end else if (init_left > 0) begin
      chk("init_req_ready", 64'(req_ready_o), 64'(0));
      chk("init_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("init_sram_req", 64'(sram_req_o), 64'(1));
      chk("init_sram_we", 64'(sram_we_o), 64'(1));
      chk("init_sram_addr", 64'(sram_addr_o), 64'(NW - init_left));
      chk("init_sram_wdata", sram_wdata_o, 64'(0));
      chk("init_sram_be", sram_be_o, {DW{1'b1}});
      init_left--;
    end else begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      chk("req_ready", 64'(req_ready_o), 64'(exp_q.size() < RD));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
      if (exp_valid && rsp_ready) begin
        chk("rsp_we", 64'(rsp_we_o), 64'(exp_q[0].we));
        chk("rsp_rdata", rsp_rdata_o, exp_q[0].data);
        void'(exp_q.pop_front());
        pop_log.push_back(cyc);
      end
      if (req_valid && req_ready_o) begin
        chk("acc_sram_req", 64'(sram_req_o), 64'(1));
        chk("acc_sram_we", 64'(sram_we_o), 64'(req_we));
        chk("acc_sram_addr", 64'(sram_addr_o), 64'(req_addr));
        chk("acc_sram_be", sram_be_o, req_we ? be_of(req_strb) : 64'(0));
        if (req_we) chk("acc_sram_wdata", sram_wdata_o, req_wdata);
        ent.we  = req_we;
        ent.cyc = cyc;
        if (req_we) begin
          for (int k = 0; k < 8; k++)
            if (req_strb[k]) ref_mem[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
          ent.data = '0;
        end else begin
          ent.data = ref_mem[req_addr];
        end
        exp_q.push_back(ent);
      end else begin
        chk("idle_sram_req", 64'(sram_req_o), 64'(0));
      end
    end
  end

  // One request through the table: check the issue cycle and the response 2 cycles later.
  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb;
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        got = 1;
        chk($sformatf("vec%0d_sram_be", idx), sram_be_o, v.exp_be);
        chk($sformatf("vec%0d_sram_addr", idx), 64'(sram_addr_o), 64'(v.addr));
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!got) chk($sformatf("vec%0d_accept_timeout", idx), 64'(0), 64'(1));
    got = 0;
    for (n = 1; n <= 10 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        got = 1;
        chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(2));
        chk($sformatf("vec%0d_rsp_we", idx), 64'(rsp_we_o), 64'(v.we));
        chk($sformatf("vec%0d_rsp_rdata", idx), rsp_rdata_o, v.exp_rdata);
      end
      @(posedge clk); #1;
    end
    if (!got) chk($sformatf("vec%0d_rsp_timeout", idx), 64'(0), 64'(1));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int acc, first_cyc;
    bit a;
    vec_t z;

    vt[0] = '{1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, {DW{1'b1}}, 64'h0};
    vt[1] = '{1'b1, 3'd3, {DW{1'b1}}, 8'h0F, 64'h0000_0000_FFFF_FFFF, 64'h0};
    vt[2] = '{1'b0, 3'd3, 64'h0, 8'h00, 64'h0, 64'hDEAD_BEEF_FFFF_FFFF};
    vt[3] = '{1'b1, 3'd5, 64'h1122_3344_5566_7788, 8'hA5, 64'hFF00_FF00_00FF_00FF, 64'h0};
    vt[4] = '{1'b0, 3'd5, 64'h0, 8'hFF, 64'h0, 64'h1100_3300_0066_0088};
    vt[5] = '{1'b0, 3'd0, 64'h0, 8'h00, 64'h0, 64'h0};
    vt[6] = '{1'b1, 3'd7, 64'hFFFF_0000_FFFF_0000, 8'h00, 64'h0, 64'h0};
    vt[7] = '{1'b0, 3'd7, 64'h0, 8'h00, 64'h0, 64'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef SRAM_CTRL_ZERO_INIT_EN
    // Swept memory reads back as zero.
    z = '{1'b0, 3'd5, 64'h0, 8'h00, 64'h0, 64'h0};
    run_vec(z, 99);
`endif

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);
    drain();

    // Back-to-back reads at full throughput.
    pop_log.delete();
    rsp_ready = 1'b1;
    first_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(i);
      @(negedge clk);
      chk("b2b_req_ready", 64'(req_ready_o), 64'(1));
      if (i == 0) first_cyc = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_rsp_count", 64'(pop_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < pop_log.size(); i++)
      chk($sformatf("b2b_rsp_cycle%0d", i), 64'(pop_log[i]), 64'(first_cyc + 2 + i));

    // Back-pressure: only RSP_DEPTH reads get in while responses are held.
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int n = 0; n < 8 && acc < 6; n++) begin
      req_addr = 3'(acc + 1);
      @(negedge clk); a = req_ready_o;
      @(posedge clk); #1;
      if (a) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'(RD));
    @(negedge clk);
    chk("bp_ready_low", 64'(req_ready_o), 64'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && acc < 6; n++) begin
      req_addr = 3'(acc + 1);
      @(negedge clk); a = req_ready_o;
      @(posedge clk); #1;
      if (a) acc++;
    end
    chk("bp_total_accepted", 64'(acc), 64'(6));
    drain();

    // Reset with two responses queued and one in flight.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 3'(i);
      @(negedge clk);
      chk("rst_seq_ready", 64'(req_ready_o), 64'(1));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", 64'(rsp_valid_o), 64'(0));
    rsp_ready = 1'b1;
    repeat (14) @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, NW - 1));
      req_wdata = {$urandom, $urandom};
      req_strb  = 8'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
